swo_uart_rx: RTL

Receives the asynchronous SWO pin in NRZ (UART) mode and recovers 8-bit bytes for the trace capture path. Sits directly upstream of the SWO input of the trace capture top level: it samples the front-panel SWO line, which has already been selected per board revision, and presents one validated byte per strobe to the capture/pattern-match logic. Runs entirely in the trace clock domain. The bit rate is set at runtime by a divider register.

---
 rtl/swo_rx_pkg.sv | 15 +
 rtl/swo_bit_timer.sv | 25 ++
 rtl/swo_uart_rx.sv | 139 +++++++++++++
 3 files changed

// File: rtl/swo_rx_pkg.sv
// Shared types and constants for the SWO NRZ (UART) receiver.
package swo_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

    localparam int MIN_DIV = 3;
    localparam int BYTE_W  = 8;

endpackage

// File: rtl/swo_bit_timer.sv
// Bit-period down-counter: load takes priority, expiry while the count sits at 0.
module swo_bit_timer #(
    parameter int pDIV_WIDTH = 12
) (
    input  logic                  trace_clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [pDIV_WIDTH-1:0] load_val,
    output logic                  expired
);

    logic [pDIV_WIDTH-1:0] cnt;

    always_ff @(posedge trace_clk) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/swo_uart_rx.sv
// SWO NRZ receiver: recovers LSB-first 8N1 bytes at a runtime bit-period divider.
// Optional SWO_RX_STATS_EN adds saturating byte / error counters.
module swo_uart_rx
    import swo_rx_pkg::*;
#(
    parameter int pDIV_WIDTH = 12
) (
    input  logic                  trace_clk,
    input  logic                  reset,
    input  logic                  swo,
    input  logic                  I_enable,
    input  logic [pDIV_WIDTH-1:0] I_swo_bitrate_div,
    output logic [7:0]            O_data,
    output logic                  O_data_valid,
    output logic                  O_framing_error,
    output logic                  O_rx_active
`ifdef SWO_RX_STATS_EN
    ,
    output logic [15:0]           O_byte_count,
    output logic [15:0]           O_error_count
`endif
);

    rx_state_e             state;
    logic                  swo_m, swo_s, swo_p;
    logic                  fall;
    logic [pDIV_WIDTH-1:0] div_eff, div_l;
    logic [BYTE_W-1:0]     shreg;
    logic [2:0]            bitcnt;
    logic                  tmr_load, tmr_exp;
    logic [pDIV_WIDTH-1:0] tmr_val;

    // Line idles high, so the synchronizer resets to 1 to avoid a phantom start edge.
    always_ff @(posedge trace_clk) begin
        if (reset) begin
            swo_m <= 1'b1;
            swo_s <= 1'b1;
            swo_p <= 1'b1;
        end else begin
            swo_m <= swo;
            swo_s <= swo_m;
            swo_p <= swo_s;
        end
    end

    assign fall    = swo_p & ~swo_s;
    assign div_eff = (I_swo_bitrate_div < pDIV_WIDTH'(MIN_DIV)) ? pDIV_WIDTH'(MIN_DIV)
                                                                 : I_swo_bitrate_div;

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = div_l;
        if (I_enable) begin
            case (state)
                IDLE: if (fall) begin
                    tmr_load = 1'b1;
                    tmr_val  = div_eff >> 1;
                end
                START, DATA: tmr_load = tmr_exp;
                default: ;
            endcase
        end
    end

    swo_bit_timer #(.pDIV_WIDTH(pDIV_WIDTH)) u_timer (
        .trace_clk (trace_clk),
        .reset     (reset),
        .load      (tmr_load),
        .load_val  (tmr_val),
        .expired   (tmr_exp)
    );

    always_ff @(posedge trace_clk) begin
        if (reset) begin
            state           <= IDLE;
            div_l           <= pDIV_WIDTH'(MIN_DIV);
            shreg           <= '0;
            bitcnt          <= '0;
            O_data          <= 8'h00;
            O_data_valid    <= 1'b0;
            O_framing_error <= 1'b0;
        end else begin
            O_data_valid    <= 1'b0;
            O_framing_error <= 1'b0;
            if (!I_enable) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (fall) begin
                        state <= START;
                        div_l <= div_eff;
                    end
                    START: if (tmr_exp) begin
                        bitcnt <= '0;
                        state  <= swo_s ? IDLE : DATA;
                    end
                    DATA: if (tmr_exp) begin
                        shreg  <= {swo_s, shreg[BYTE_W-1:1]};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'(BYTE_W - 1))
                            state <= STOP;
                    end
                    STOP: if (tmr_exp) begin
                        if (swo_s) begin
                            O_data       <= shreg;
                            O_data_valid <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            O_framing_error <= 1'b1;
                            state           <= BREAK;
                        end
                    end
                    BREAK: if (swo_s) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign O_rx_active = (state != IDLE);

`ifdef SWO_RX_STATS_EN
    logic false_start;
    assign false_start = I_enable && (state == START) && tmr_exp && swo_s;

    always_ff @(posedge trace_clk) begin
        if (reset) begin
            O_byte_count  <= 16'h0000;
            O_error_count <= 16'h0000;
        end else begin
            if (O_data_valid && O_byte_count != 16'hFFFF)
                O_byte_count <= O_byte_count + 16'd1;
            if ((O_framing_error || false_start) && O_error_count != 16'hFFFF)
                O_error_count <= O_error_count + 16'd1;
        end
    end
`endif

endmodule
